// File: rtl/spi_sclk_gen.sv
// SPI serial clock generator: SPPR/SPR divisor, all CPOL/CPHA modes, framed transfers
// with start/busy/done handshake and per-edge sample/shift strobes plus early pre-strobes.
module spi_sclk_gen #(
    parameter int unsigned PRE_W  = 3,
    parameter int unsigned RATE_W = 3,
    parameter int unsigned CNT_W  = 12,
    parameter int unsigned LEN_W  = 5
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               en,
    input  logic               start,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic               cpol,
    input  logic               cpha,
    input  logic [PRE_W-1:0]   sppr,
    input  logic [RATE_W-1:0]  spr,
    output logic [CNT_W:0]     baudratedivisor,
    output logic               sclk,
    output logic               busy,
    output logic               done,
    output logic               sample_stb,
    output logic               shift_stb,
    output logic               pre_sample_stb,
    output logic               pre_shift_stb,
    output logic [LEN_W:0]     edge_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        TRAIL
    } state_t;

    state_t              state, state_nxt;
    logic                sclk_nxt, busy_nxt, done_nxt, sample_nxt, shift_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [LEN_W:0]      edge_nxt;
    logic                cpol_s, cpol_s_nxt;
    logic                cpha_s, cpha_s_nxt;
    logic [PRE_W-1:0]    sppr_s, sppr_s_nxt;
    logic [RATE_W-1:0]   spr_s, spr_s_nxt;
    logic [LEN_W-1:0]    len_s, len_s_nxt;

    logic [CNT_W:0]      div_base;
    logic [CNT_W-1:0]    half;
    logic [CNT_W-1:0]    half_m1;
    logic                at_edge;
    logic                shift_class;
    logic [LEN_W:0]      edge_inc;
    logic [LEN_W:0]      last_edge;

    // Shift amount widened by one bit so spr at its maximum does not wrap.
    assign div_base        = (CNT_W+1)'(sppr) + (CNT_W+1)'(1);
    assign baudratedivisor = div_base << ({1'b0, spr} + (RATE_W+1)'(1));

    assign half        = (CNT_W'(sppr_s) + CNT_W'(1)) << spr_s;
    assign half_m1     = half - CNT_W'(1);
    assign at_edge     = (cnt == half_m1);
    assign shift_class = edge_cnt[0] ^ cpha_s;
    assign edge_inc    = edge_cnt + (LEN_W+1)'(1);
    assign last_edge   = {len_s, 1'b0};

    assign pre_sample_stb = (state == RUN) && en && at_edge && !shift_class;
    assign pre_shift_stb  = (state == RUN) && en && at_edge &&  shift_class;

    always_comb begin
        state_nxt  = state;
        sclk_nxt   = sclk;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        sample_nxt = 1'b0;
        shift_nxt  = 1'b0;
        cnt_nxt    = cnt;
        edge_nxt   = edge_cnt;
        cpol_s_nxt = cpol_s;
        cpha_s_nxt = cpha_s;
        sppr_s_nxt = sppr_s;
        spr_s_nxt  = spr_s;
        len_s_nxt  = len_s;

        case (state)
            IDLE: begin
                sclk_nxt = cpol;
                if (start && en && (frame_len != '0)) begin
                    cpol_s_nxt = cpol;
                    cpha_s_nxt = cpha;
                    sppr_s_nxt = sppr;
                    spr_s_nxt  = spr;
                    len_s_nxt  = frame_len;
                    busy_nxt   = 1'b1;
                    cnt_nxt    = '0;
                    edge_nxt   = '0;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_nxt = IDLE;
                    sclk_nxt  = cpol_s;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    edge_nxt  = '0;
                end else if (at_edge) begin
                    cnt_nxt    = '0;
                    sclk_nxt   = ~sclk;
                    edge_nxt   = edge_inc;
                    shift_nxt  = shift_class;
                    sample_nxt = !shift_class;
                    if (edge_inc == last_edge) begin
                        state_nxt = TRAIL;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            TRAIL: begin
                if (!en) begin
                    state_nxt = IDLE;
                    sclk_nxt  = cpol_s;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    edge_nxt  = '0;
                end else if (at_edge) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state      <= IDLE;
            sclk       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_stb <= 1'b0;
            shift_stb  <= 1'b0;
            cnt        <= '0;
            edge_cnt   <= '0;
            cpol_s     <= 1'b0;
            cpha_s     <= 1'b0;
            sppr_s     <= '0;
            spr_s      <= '0;
            len_s      <= '0;
        end else begin
            state      <= state_nxt;
            sclk       <= sclk_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            sample_stb <= sample_nxt;
            shift_stb  <= shift_nxt;
            cnt        <= cnt_nxt;
            edge_cnt   <= edge_nxt;
            cpol_s     <= cpol_s_nxt;
            cpha_s     <= cpha_s_nxt;
            sppr_s     <= sppr_s_nxt;
            spr_s      <= spr_s_nxt;
            len_s      <= len_s_nxt;
        end
    end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: expected edge/done events are queued at start and matched
// against strobe events logged by a monitor.
module tb_spi_sclk_gen;

    logic        pclk = 1'b0;
    logic        presetn, en, start, cpol, cpha;
    logic [2:0]  sppr, spr;
    logic [4:0]  frame_len;
    logic [12:0] baudratedivisor;
    logic        sclk, busy, done, sample_stb, shift_stb, pre_sample_stb, pre_shift_stb;
    logic [5:0]  edge_cnt;

    spi_sclk_gen #(.PRE_W(3), .RATE_W(3), .CNT_W(12), .LEN_W(5)) dut (
        .pclk(pclk), .presetn(presetn), .en(en), .start(start), .frame_len(frame_len),
        .cpol(cpol), .cpha(cpha), .sppr(sppr), .spr(spr),
        .baudratedivisor(baudratedivisor), .sclk(sclk), .busy(busy), .done(done),
        .sample_stb(sample_stb), .shift_stb(shift_stb),
        .pre_sample_stb(pre_sample_stb), .pre_shift_stb(pre_shift_stb), .edge_cnt(edge_cnt)
    );

    always #5 pclk = ~pclk;

    // kind: 0 sample edge, 1 shift edge, 2 done pulse
    typedef struct packed {
        int         cyc;
        logic [1:0] kind;
        logic       sclk;
        logic [5:0] ecnt;
        logic       pre;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  obs_q[$];
    int   cyc = 0;
    int   busy_total = 0;
    logic prev_pre_s = 1'b0, prev_pre_h = 1'b0;
    int   errors = 0, checks = 0;

    function automatic ev_t mk_ev(int c, logic [1:0] k, logic s, logic [5:0] n, logic p);
        ev_t e;
        e.cyc = c; e.kind = k; e.sclk = s; e.ecnt = n; e.pre = p;
        return e;
    endfunction

    function automatic string fmt(ev_t e);
        return $sformatf("cyc=%0d kind=%0d sclk=%0b ecnt=%0d pre=%0b", e.cyc, e.kind, e.sclk, e.ecnt, e.pre);
    endfunction

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (done)            obs_q.push_back(mk_ev(cyc, 2'd2, sclk, edge_cnt, 1'b0));
        else if (shift_stb)  obs_q.push_back(mk_ev(cyc, 2'd1, sclk, edge_cnt, prev_pre_h));
        else if (sample_stb) obs_q.push_back(mk_ev(cyc, 2'd0, sclk, edge_cnt, prev_pre_s));
        if (busy) busy_total <= busy_total + 1;
        prev_pre_s <= pre_sample_stb;
        prev_pre_h <= pre_shift_stb;
    end

    // Edge k lands k*H cycles after the start-sampling edge; done follows one more H.
    function automatic void push_frame(int s, int len, int h, logic pol, logic pha, int nedges, logic with_done);
        logic odd;
        for (int k = 1; k <= nedges; k++) begin
            odd = (k % 2) == 1;
            exp_q.push_back(mk_ev(s + 1 + k * h, (odd ^ pha) ? 2'd0 : 2'd1, pol ^ odd, 6'(k), 1'b1));
        end
        if (with_done)
            exp_q.push_back(mk_ev(s + 1 + (2 * len + 1) * h, 2'd2, pol, 6'(2 * len), 1'b0));
    endfunction

    task automatic start_frame(input logic pol, input logic pha, input logic [2:0] pp,
                               input logic [2:0] rr, input logic [4:0] len, output int s);
        @(negedge pclk);
        cpol = pol; cpha = pha; sppr = pp; spr = rr; frame_len = len; start = 1'b1;
        s = cyc;
        @(negedge pclk);
        start = 1'b0;
    endtask

    task automatic sb_drain(input string name, input int deadline);
        ev_t o, e;
        while (exp_q.size() != 0 && cyc <= deadline) begin
            @(negedge pclk); #1;
            while (obs_q.size() != 0 && exp_q.size() != 0) begin
                o = obs_q.pop_front();
                e = exp_q.pop_front();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s: got %s, want %s", name, fmt(o), fmt(e));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d events still pending, want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge pclk);
        #1;
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s_extra: got %0d unexpected events (first %s), want 0", name, obs_q.size(), fmt(obs_q[0]));
            obs_q.delete();
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0; en = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0;
        sppr = 3'd0; spr = 3'd0; frame_len = 5'd0;
        #12;
        checks++;
        if ({sclk, busy, done, sample_stb, shift_stb, pre_sample_stb, pre_shift_stb} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want 0000000",
                     {sclk, busy, done, sample_stb, shift_stb, pre_sample_stb, pre_shift_stb});
        end
        checks++;
        if (edge_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_edge_cnt: got %0d, want 0", edge_cnt);
        end
        checks++;
        if (baudratedivisor !== 13'd2) begin
            errors++; $display("FAIL reset_divisor: got %0d, want 2", baudratedivisor);
        end
        @(negedge pclk);
        presetn = 1'b1; en = 1'b1;
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_h1();
        int s, b0;
        b0 = busy_total;
        start_frame(1'b0, 1'b0, 3'd0, 3'd0, 5'd8, s);
        push_frame(s, 8, 1, 1'b0, 1'b0, 16, 1'b1);
        sb_drain("h1_frame", s + 1 + 17 + 5);
        checks++;
        if (busy_total - b0 !== 17) begin
            errors++; $display("FAIL h1_busy_cycles: got %0d, want 17", busy_total - b0);
        end
        checks++;
        if (sclk !== 1'b0) begin
            errors++; $display("FAIL h1_sclk_idle: got %b, want 0", sclk);
        end
    endtask

    task automatic test_mode3();
        int s;
        @(negedge pclk);
        cpol = 1'b1; cpha = 1'b1; sppr = 3'd2; spr = 3'd1;
        @(negedge pclk); #1;
        checks++;
        if (baudratedivisor !== 13'd12) begin
            errors++; $display("FAIL m3_divisor: got %0d, want 12", baudratedivisor);
        end
        checks++;
        if (sclk !== 1'b1) begin
            errors++; $display("FAIL m3_sclk_idle: got %b, want 1", sclk);
        end
        start_frame(1'b1, 1'b1, 3'd2, 3'd1, 5'd4, s);
        push_frame(s, 4, 6, 1'b1, 1'b1, 8, 1'b1);
        sb_drain("m3_frame", s + 1 + 9 * 6 + 5);
        checks++;
        if (sclk !== 1'b1) begin
            errors++; $display("FAIL m3_sclk_end: got %b, want 1", sclk);
        end
    endtask

    task automatic test_modes();
        int s;
        for (int m = 0; m < 4; m++) begin
            start_frame(m[1], m[0], 3'd1, 3'd0, 5'd1, s);
            push_frame(s, 1, 2, m[1], m[0], 2, 1'b1);
            sb_drain($sformatf("mode%0d_frame", m), s + 1 + 3 * 2 + 5);
        end
    endtask

    task automatic test_abort();
        int s, t;
        start_frame(1'b1, 1'b0, 3'd1, 3'd0, 5'd4, s);
        push_frame(s, 4, 2, 1'b1, 1'b0, 3, 1'b0);
        t = 0;
        while (edge_cnt !== 6'd3 && t < 50) begin
            @(negedge pclk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++; $display("FAIL abort_wait_edge3: got edge_cnt=%0d, want 3", edge_cnt);
        end
        en = 1'b0;
        @(negedge pclk); #1;
        checks++;
        if ({sclk, busy, done, sample_stb, shift_stb} !== 5'b10000 || edge_cnt !== 6'd0) begin
            errors++;
            $display("FAIL abort_state: got sclk,busy,done,smp,shf=%b edge_cnt=%0d, want 10000 edge_cnt=0",
                     {sclk, busy, done, sample_stb, shift_stb}, edge_cnt);
        end
        sb_drain("abort_partial", s + 20);
        repeat (20) @(negedge pclk);
        #1;
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL abort_no_done: got %0d events, want 0", obs_q.size());
            obs_q.delete();
        end
        en = 1'b1;
        start_frame(1'b1, 1'b0, 3'd1, 3'd0, 5'd2, s);
        push_frame(s, 2, 2, 1'b1, 1'b0, 4, 1'b1);
        sb_drain("abort_restart", s + 1 + 5 * 2 + 5);
    endtask

    task automatic test_ignore();
        int s;
        logic seen_busy;
        start_frame(1'b0, 1'b0, 3'd0, 3'd0, 5'd3, s);
        push_frame(s, 3, 1, 1'b0, 1'b0, 6, 1'b1);
        @(negedge pclk);
        start = 1'b1; cpha = 1'b1; cpol = 1'b1; frame_len = 5'd7; sppr = 3'd3;
        @(negedge pclk);
        start = 1'b0;
        sb_drain("ignore_frame", s + 1 + 7 + 5);
        start_frame(1'b0, 1'b0, 3'd0, 3'd0, 5'd0, s);
        en = 1'b0;
        start_frame(1'b0, 1'b0, 3'd0, 3'd0, 5'd2, s);
        seen_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            if (busy !== 1'b0) seen_busy = 1'b1;
        end
        checks++;
        if (seen_busy !== 1'b0 || obs_q.size() != 0) begin
            errors++; $display("FAIL ignore_len0_en0: got busy_seen=%b events=%0d, want 0 0", seen_busy, obs_q.size());
            obs_q.delete();
        end
        en = 1'b1;
    endtask

    task automatic test_max();
        int s;
        @(negedge pclk);
        sppr = 3'd7; spr = 3'd7;
        @(negedge pclk); #1;
        checks++;
        if (baudratedivisor !== 13'd2048) begin
            errors++; $display("FAIL max_divisor: got %0d, want 2048", baudratedivisor);
        end
        start_frame(1'b0, 1'b0, 3'd7, 3'd7, 5'd1, s);
        push_frame(s, 1, 1024, 1'b0, 1'b0, 2, 1'b1);
        sb_drain("max_frame", s + 1 + 3 * 1024 + 5);
        start_frame(1'b0, 1'b1, 3'd7, 3'd7, 5'd1, s);
        push_frame(s, 1, 1024, 1'b0, 1'b1, 1, 1'b0);
        repeat (1100) @(posedge pclk);
        #1;
        checks++;
        if (sclk !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL max_mid_run: got sclk=%b busy=%b, want 1 1", sclk, busy);
        end
        #1 presetn = 1'b0;
        #1;
        checks++;
        if ({sclk, busy, done, sample_stb, shift_stb} !== 5'b0 || edge_cnt !== 6'd0) begin
            errors++;
            $display("FAIL async_reset: got sclk,busy,done,smp,shf=%b edge_cnt=%0d, want 00000 edge_cnt=0",
                     {sclk, busy, done, sample_stb, shift_stb}, edge_cnt);
        end
        @(negedge pclk);
        presetn = 1'b1;
        sb_drain("async_reset_events", cyc + 10);
    endtask

    initial begin
        test_reset();
        test_h1();
        test_mode3();
        test_modes();
        test_abort();
        test_ignore();
        test_max();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1);
    end

endmodule
